// File: rtl/sc_backg_scroll_ctrl.sv
// Background-type row sequencer: clear/load/level-select/shift control for one row register.
// Optional: define SC_BACKGCTRL_DIRFLIP_EN to reverse the scroll direction on odd levels.
module sc_backg_scroll_ctrl #(
    parameter int unsigned          CNT_WIDTH = 24,
    parameter logic [CNT_WIDTH-1:0] PERIOD_L0 = 24'd5000000,
    parameter logic [CNT_WIDTH-1:0] PERIOD_L1 = 24'd3750000,
    parameter logic [CNT_WIDTH-1:0] PERIOD_L2 = 24'd2500000,
    parameter logic [CNT_WIDTH-1:0] PERIOD_L3 = 24'd1250000,
    parameter logic [1:0]           SHIFT_DIR = 2'b01
) (
    input  logic       SC_BACKGCTRL_CLOCK_50,
    input  logic       SC_BACKGCTRL_RESET_InLow,
    input  logic       SC_BACKGCTRL_start_InLow,
    input  logic       SC_BACKGCTRL_levelup_InLow,
    input  logic       SC_BACKGCTRL_pause_In,
    input  logic       SC_BACKGCTRL_gameover_InLow,
    output logic       SC_BACKGCTRL_clear_OutLow,
    output logic       SC_BACKGCTRL_load_OutLow,
    output logic [1:0] SC_BACKGCTRL_levelsel_Out,
    output logic [1:0] SC_BACKGCTRL_shiftselection_Out,
    output logic [2:0] SC_BACKGCTRL_state_Out
);

    typedef enum logic [2:0] {
        IDLE     = 3'b000,
        CLEAR    = 3'b001,
        LOAD     = 3'b010,
        RUN      = 3'b011,
        PAUSE    = 3'b100,
        GAMEOVER = 3'b101
    } state_t;

    state_t               state, nextState;
    logic [1:0]           level, nextLevel;
    logic [CNT_WIDTH-1:0] count, nextCount;
    logic [1:0]           nextShift;
    logic                 startPrev, levelupPrev;
    logic                 startEdge, levelupEdge;
    logic [CNT_WIDTH-1:0] period, lastCount;
    logic                 atLast;
    logic [1:0]           shiftCode;
    logic                 clearReg, loadReg;
    logic [1:0]           shiftReg;

    assign startEdge   = startPrev & ~SC_BACKGCTRL_start_InLow;
    assign levelupEdge = levelupPrev & ~SC_BACKGCTRL_levelup_InLow;

    always_comb begin
        case (level)
            2'd0:    period = PERIOD_L0;
            2'd1:    period = PERIOD_L1;
            2'd2:    period = PERIOD_L2;
            default: period = PERIOD_L3;
        endcase
    end

    // Periods of 0 and 1 both collapse to a terminal count of 0: tick every cycle.
    assign lastCount = (period <= CNT_WIDTH'(1)) ? '0 : period - CNT_WIDTH'(1);
    assign atLast    = (count == lastCount);

`ifdef SC_BACKGCTRL_DIRFLIP_EN
    assign shiftCode = level[0] ? {SHIFT_DIR[0], SHIFT_DIR[1]} : SHIFT_DIR;
`else
    assign shiftCode = SHIFT_DIR;
`endif

    always_comb begin
        nextState = state;
        nextLevel = level;
        nextCount = count;
        nextShift = 2'b00;
        case (state)
            IDLE: begin
                if (startEdge) nextState = CLEAR;
            end
            CLEAR: begin
                nextLevel = '0;
                nextCount = '0;
                nextState = LOAD;
            end
            LOAD: begin
                nextCount = '0;
                nextState = RUN;
            end
            RUN, PAUSE: begin
                if (!SC_BACKGCTRL_gameover_InLow) begin
                    nextState = GAMEOVER;
                end else if (levelupEdge) begin
                    nextLevel = (level == 2'd3) ? 2'd3 : level + 2'd1;
                    nextCount = '0;
                    nextState = LOAD;
                end else if (state == PAUSE) begin
                    if (!SC_BACKGCTRL_pause_In) nextState = RUN;
                end else if (SC_BACKGCTRL_pause_In) begin
                    // Last RUN cycle still counts, but never past the terminal value so the tick survives the pause.
                    nextState = PAUSE;
                    if (!atLast) nextCount = count + CNT_WIDTH'(1);
                end else if (atLast) begin
                    nextCount = '0;
                    nextShift = shiftCode;
                end else begin
                    nextCount = count + CNT_WIDTH'(1);
                end
            end
            GAMEOVER: begin
                if (startEdge) nextState = CLEAR;
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge SC_BACKGCTRL_CLOCK_50 or negedge SC_BACKGCTRL_RESET_InLow) begin
        if (!SC_BACKGCTRL_RESET_InLow) begin
            state       <= IDLE;
            level       <= '0;
            count       <= '0;
            startPrev   <= 1'b1;
            levelupPrev <= 1'b1;
            clearReg    <= 1'b0;
            loadReg     <= 1'b1;
            shiftReg    <= 2'b00;
        end else begin
            state       <= nextState;
            level       <= nextLevel;
            count       <= nextCount;
            startPrev   <= SC_BACKGCTRL_start_InLow;
            levelupPrev <= SC_BACKGCTRL_levelup_InLow;
            clearReg    <= ~((nextState == IDLE) || (nextState == CLEAR));
            loadReg     <= ~(nextState == LOAD);
            shiftReg    <= nextShift;
        end
    end

    assign SC_BACKGCTRL_clear_OutLow       = clearReg;
    assign SC_BACKGCTRL_load_OutLow        = loadReg;
    assign SC_BACKGCTRL_levelsel_Out       = level;
    assign SC_BACKGCTRL_shiftselection_Out = shiftReg;
    assign SC_BACKGCTRL_state_Out          = state;

endmodule

// File: tb/tb_sc_backg_scroll_ctrl.sv
// Bench for sc_backg_scroll_ctrl: vector table plus hand-written reset sequence, scoreboard-checked.
module tb_sc_backg_scroll_ctrl;

    logic       clk;
    logic       rstN;
    logic       startN, levelupN, pauseIn, gameoverN;
    logic       clrN, loadN;
    logic [1:0] levelSel, shiftSel;
    logic [2:0] stateOut;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       s, l, p, g;
        logic       clr, ld;
        logic [1:0] lv;
        logic       tick;
        logic [2:0] st;
    } vec_t;

    typedef struct {
        logic       clr, ld;
        logic [1:0] lv, sh;
        logic [2:0] st;
    } exp_t;

    vec_t vecs[$];
    exp_t sbq[$];

    sc_backg_scroll_ctrl #(
        .CNT_WIDTH(24),
        .PERIOD_L0(24'd4),
        .PERIOD_L1(24'd3),
        .PERIOD_L2(24'd2),
        .PERIOD_L3(24'd2),
        .SHIFT_DIR(2'b01)
    ) dut (
        .SC_BACKGCTRL_CLOCK_50(clk),
        .SC_BACKGCTRL_RESET_InLow(rstN),
        .SC_BACKGCTRL_start_InLow(startN),
        .SC_BACKGCTRL_levelup_InLow(levelupN),
        .SC_BACKGCTRL_pause_In(pauseIn),
        .SC_BACKGCTRL_gameover_InLow(gameoverN),
        .SC_BACKGCTRL_clear_OutLow(clrN),
        .SC_BACKGCTRL_load_OutLow(loadN),
        .SC_BACKGCTRL_levelsel_Out(levelSel),
        .SC_BACKGCTRL_shiftselection_Out(shiftSel),
        .SC_BACKGCTRL_state_Out(stateOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [1:0] dirFor(input logic [1:0] lv);
`ifdef SC_BACKGCTRL_DIRFLIP_EN
        return lv[0] ? 2'b10 : 2'b01;
`else
        return 2'b01;
`endif
    endfunction

    task automatic v(input logic s, l, p, g, clr, ld, input logic [1:0] lv,
                     input logic tick, input logic [2:0] st);
        vec_t r;
        r.s = s; r.l = l; r.p = p; r.g = g;
        r.clr = clr; r.ld = ld; r.lv = lv; r.tick = tick; r.st = st;
        vecs.push_back(r);
    endtask

    task automatic pushExp(input logic clr, ld, input logic [1:0] lv, sh, input logic [2:0] st);
        exp_t e;
        e.clr = clr; e.ld = ld; e.lv = lv; e.sh = sh; e.st = st;
        sbq.push_back(e);
    endtask

    task automatic checkNext(input string tag);
        exp_t e;
        total++;
        if (sbq.size() == 0) begin
            bad++;
            $display("FAIL %s: scoreboard empty", tag);
            return;
        end
        e = sbq.pop_front();
        if ({clrN, loadN, levelSel, shiftSel, stateOut} !== {e.clr, e.ld, e.lv, e.sh, e.st}) begin
            bad++;
            $display("FAIL %s: got clr=%b ld=%b lv=%b sh=%b st=%0d, want clr=%b ld=%b lv=%b sh=%b st=%0d",
                     tag, clrN, loadN, levelSel, shiftSel, stateOut, e.clr, e.ld, e.lv, e.sh, e.st);
        end
    endtask

    initial begin
        // args: start, levelup, pause, gameover | clr, load, level, tick, state
        v(1,1,0,1, 0,1,0,0,0);                                   // idle
        v(0,1,0,1, 0,1,0,0,1);                                   // start -> CLEAR
        v(0,1,0,1, 1,0,0,0,2);                                   // held low: single event
        v(1,1,0,1, 1,1,0,0,3);                                   // RUN, count 0
        for (int unsigned i = 0; i < 3; i++) v(1,1,0,1, 1,1,0,0,3);
        v(1,1,0,1, 1,1,0,1,3);                                   // first tick
        for (int unsigned i = 0; i < 3; i++) v(1,1,0,1, 1,1,0,0,3);
        v(1,1,0,1, 1,1,0,1,3);
        v(1,1,0,1, 1,1,0,0,3);
        v(1,1,0,1, 1,1,0,0,3);                                   // count = 2
        for (int unsigned i = 0; i < 10; i++) v(1,1,1,1, 1,1,0,0,4);
        v(1,1,0,1, 1,1,0,0,3);                                   // pause dropped
        v(1,1,0,1, 1,1,0,1,3);                                   // tick 2 cycles later
        v(1,1,0,1, 1,1,0,0,3);
        v(1,0,0,1, 1,0,1,0,2);                                   // level-up -> 1
        v(1,1,0,1, 1,1,1,0,3);
        for (int unsigned k = 0; k < 2; k++) begin
            v(1,1,0,1, 1,1,1,0,3);
            v(1,1,0,1, 1,1,1,0,3);
            v(1,1,0,1, 1,1,1,1,3);                               // period 3
        end
        v(1,0,0,1, 1,0,2,0,2);                                   // level-up -> 2
        v(1,1,0,1, 1,1,2,0,3);
        for (int unsigned k = 0; k < 2; k++) begin
            v(1,1,0,1, 1,1,2,0,3);
            v(1,1,0,1, 1,1,2,1,3);                               // period 2
        end
        v(1,0,0,1, 1,0,3,0,2);                                   // level-up -> 3
        v(1,1,0,1, 1,1,3,0,3);
        v(1,1,0,1, 1,1,3,0,3);
        v(1,1,0,1, 1,1,3,1,3);
        v(1,0,0,1, 1,0,3,0,2);                                   // saturated, still loads
        v(1,1,0,1, 1,1,3,0,3);
        v(1,1,0,1, 1,1,3,0,3);                                   // count at terminal
        v(1,0,0,1, 1,0,3,0,2);                                   // level-up beats tick
        v(1,1,0,1, 1,1,3,0,3);
        v(1,1,0,1, 1,1,3,0,3);
        v(1,0,0,0, 1,1,3,0,5);                                   // gameover beats level-up
        v(1,1,0,0, 1,1,3,0,5);
        v(1,1,0,1, 1,1,3,0,5);
        v(1,0,0,1, 1,1,3,0,5);                                   // level-up ignored
        v(0,1,0,1, 0,1,3,0,1);                                   // restart
        v(1,1,0,1, 1,0,0,0,2);
        v(1,1,0,1, 1,1,0,0,3);
        v(0,1,0,1, 1,1,0,0,3);                                   // start ignored in RUN
        v(1,1,0,1, 1,1,0,0,3);
        v(1,1,0,1, 1,1,0,0,3);
        v(1,1,0,1, 1,1,0,1,3);

        rstN = 1'b0; startN = 1'b1; levelupN = 1'b1; pauseIn = 1'b0; gameoverN = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        pushExp(0, 1, 2'b00, 2'b00, 3'd0);
        checkNext("reset_state");
        @(negedge clk);
        rstN = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            startN    = vecs[i].s;
            levelupN  = vecs[i].l;
            pauseIn   = vecs[i].p;
            gameoverN = vecs[i].g;
            pushExp(vecs[i].clr, vecs[i].ld, vecs[i].lv,
                    vecs[i].tick ? dirFor(vecs[i].lv) : 2'b00, vecs[i].st);
            @(posedge clk);
            #1;
            checkNext($sformatf("vec%0d", i));
        end

        // Shift is being emitted; pull reset between edges and expect an immediate clear.
        #2;
        rstN = 1'b0;
        pushExp(0, 1, 2'b00, 2'b00, 3'd0);
        #1;
        checkNext("async_reset");
        @(posedge clk);
        #1;
        pushExp(0, 1, 2'b00, 2'b00, 3'd0);
        checkNext("reset_held");
        @(negedge clk);
        rstN = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        pushExp(0, 1, 2'b00, 2'b00, 3'd0);
        checkNext("idle_after_reset");

`ifdef SC_BACKGCTRL_DIRFLIP_EN
        // Odd level reversal: start, one level-up, wait for the first level-1 tick.
        startN = 1'b0;
        repeat (3) @(posedge clk);
        startN = 1'b1;
        levelupN = 1'b0;
        @(posedge clk);
        levelupN = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        pushExp(1, 1, 2'b01, 2'b10, 3'd3);
        checkNext("dirflip_level1");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sc_backg_scroll_ctrl.md
Name: sc_backg_scroll_ctrl

Overview:
- Sequencer for the background-type row register used by the game lanes.
- Drives the row register's clear, load, level-select and shift-selection inputs.
- Produces per-level periodic scroll shifts, reloads the level pattern on level-up, and freezes the row on pause or game over.
- Sits between the game FSM (start, level-up, pause and game-over strobes) and one row register instance.

Parameters:
- CNT_WIDTH, 24, width of the scroll-period counter.
- PERIOD_L0, 24'd5000000, clock cycles between shifts at level 0.
- PERIOD_L1, 24'd3750000, clock cycles between shifts at level 1.
- PERIOD_L2, 24'd2500000, clock cycles between shifts at level 2.
- PERIOD_L3, 24'd1250000, clock cycles between shifts at level 3.
- SHIFT_DIR, 2'b01, base shift code emitted on a tick (01 = rotate left, 10 = rotate right).

Ports:
- SC_BACKGCTRL_CLOCK_50  in  1  system clock.
- SC_BACKGCTRL_RESET_InLow  in  1  asynchronous reset, active-low.
- SC_BACKGCTRL_start_InLow  in  1  start/restart request, active-low, falling-edge detected.
- SC_BACKGCTRL_levelup_InLow  in  1  level-up request, active-low, falling-edge detected.
- SC_BACKGCTRL_pause_In  in  1  high = hold scrolling (level-sensitive).
- SC_BACKGCTRL_gameover_InLow  in  1  game-over, active-low, level-sensitive.
- SC_BACKGCTRL_clear_OutLow  out  1  row register clear, active-low.
- SC_BACKGCTRL_load_OutLow  out  1  row register level-pattern load, active-low.
- SC_BACKGCTRL_levelsel_Out  out  2  level select to row register (00..11).
- SC_BACKGCTRL_shiftselection_Out  out  2  shift code to row register; 00 = hold.
- SC_BACKGCTRL_state_Out  out  3  current FSM state, for debug/HUD.

Behaviour:
- One clock.
- Reset is asynchronous and active-low: SC_BACKGCTRL_RESET_InLow low forces all state immediately.
- All outputs are registered; state is Moore-decoded.
- Reset values:
  - state = IDLE (000), level = 00, counter = 0.
  - clear_OutLow = 0, load_OutLow = 1, shiftselection = 00.
  - Edge-detect flops preset to 1.
- States and transitions:
  - IDLE (000): clear_OutLow held 0. Start falling edge -> CLEAR.
  - CLEAR (001): one cycle; clear_OutLow = 0; level <= 00; counter <= 0. Always -> LOAD.
  - LOAD (010): one cycle; load_OutLow = 0; levelsel_Out = level. Always -> RUN.
  - RUN (011): counter increments each cycle.
    - When counter == PERIOD_Lx - 1 (x = current level), counter <= 0 and shiftselection = SHIFT_DIR for exactly one cycle; otherwise 00.
    - First shift occurs PERIOD_Lx cycles after entering RUN.
  - PAUSE (100): counter frozen (not cleared); shiftselection = 00. pause_In low -> RUN, and counting resumes from the held value.
  - GAMEOVER (101): shiftselection = 00; row contents frozen. Start falling edge -> CLEAR.
- Priority in RUN/PAUSE, evaluated each cycle: gameover > levelup > pause > tick.
  - gameover_InLow = 0 -> GAMEOVER.
  - levelup edge -> level <= min(level+1, 3) (saturating); counter <= 0; -> LOAD.
  - pause_In = 1 -> PAUSE.
- Simultaneous tick and level-up: no shift is emitted; level-up wins.
- Level-up at level 3: level stays 3, and LOAD is still performed (pattern reload).
- Start edge in RUN/PAUSE: ignored. Level-up edge in IDLE/CLEAR/LOAD/GAMEOVER: ignored (not queued).
- levelsel_Out always reflects the level register, not only during LOAD.
- Reset mid-RUN: outputs return to reset values asynchronously; a pending tick is lost.
- Edge detection uses a one-flop history on each strobe; a held-low input produces a single event.
- Period compare is on the full CNT_WIDTH. A PERIOD value of 0 or 1 yields a tick every cycle.

Optional Feature:
- Macro: SC_BACKGCTRL_DIRFLIP_EN.
- Defined: on odd levels (01, 11) the emitted shift code is the bit-swap of SHIFT_DIR (01 <-> 10), so alternate levels scroll the opposite way.
- Not defined: SHIFT_DIR is emitted at every level; the flip logic is absent.

Test Plan:
- Common bench parameters: PERIOD_L0 = 4, PERIOD_L1 = 3, PERIOD_L2 = 2, PERIOD_L3 = 2, SHIFT_DIR = 01.
- Reset then start pulse low at cycle N -> clear_OutLow = 0 at N+1; load_OutLow = 0 and levelsel = 00 at N+2; state = RUN at N+3; shiftselection = 01 for one cycle at N+7, N+11, N+15.
- Hold pause_In = 1 for 10 cycles starting when the counter = 2 -> no shift during pause; first shift arrives 2 cycles after pause_In drops.
- Three level-up pulses -> one LOAD cycle each with levelsel 01, 10, 11; a fourth pulse -> levelsel stays 11, LOAD still pulses; shift spacing changes to 3, then 2 cycles.
- Level-up coinciding with a tick cycle -> shiftselection stays 00, LOAD next cycle. gameover_InLow = 0 together with a level-up edge -> GAMEOVER, level unchanged.
- Assert reset low mid-RUN, asynchronously between clock edges -> outputs immediately clear_OutLow = 0, shiftselection = 00, state = 000. With SC_BACKGCTRL_DIRFLIP_EN defined, level 01 emits shift code 10.
